// File: rtl/nqueen_solver.sv
// -----------------------------------------------------------------------------
// nqueen_solver
//   Parametrised N-queens backtracking solver. Each row keeps its queen as a
//   one-hot column word (bit N-1 = column 0, the leftmost). A rejected
//   candidate shifts right by one. An all-zero word means the row has run out
//   of columns. A combinational attack check compares the candidate row with
//   every row placed above it in a single cycle. Every solution is streamed
//   out row by row over a valid/ready handshake.
//
//   Handshake: a beat transfers on a rising edge where out_valid && out_ready.
//   While out_valid is high and out_ready is low, out_data/out_row/out_last
//   hold. out_valid never drops without a transfer, except on reset.
//
//   Parameters
//     N      board size / number of queens (4..16)
//     CNT_W  width of solution_count (wraps)
//   Ports
//     clk            rising-edge clock
//     rst            asynchronous active-high reset
//     start          begin a new search (ignored while busy)
//     busy           search or emit in progress
//     done           search finished; cleared by the next accepted start
//     out_valid      solution beat valid
//     out_ready      consumer ready
//     out_data       one-hot queen column for row out_row
//     out_row        row index of the current beat
//     out_last       last beat of a solution (out_row == N-1)
//     solution_count solutions emitted since last start
//   Configuration macro
//     NQUEEN_FIRST_ONLY_EN  stop after the first solution has been emitted
// -----------------------------------------------------------------------------
module nqueen_solver #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_row,
  output logic                 out_last,
  output logic [CNT_W-1:0]     solution_count
);

  localparam int R_W = $clog2(N);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_EMIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [N-1:0]   COL0     = {1'b1, {(N-1){1'b0}}};
  localparam logic [R_W-1:0] LAST_ROW = R_W'(N-1);

  logic [1:0]       state_q, state_d;
  logic [R_W-1:0]   r_q, r_d;
  logic [R_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     pos_q [N];
  logic [N-1:0]     pos_d [N];

  logic [N-1:0]     cand;
  logic             safe;

  // Attack check of the candidate against rows 0..r-1 only. Rows at or
  // below r hold stale words from earlier branches and must not count.
  always_comb begin
    cand = pos_q[r_q];
    safe = 1'b1;
    for (int j = 0; j < N; j++) begin
      if (j < int'(r_q)) begin
        if ((pos_q[j] == cand) ||
            (pos_q[j] == (cand << (int'(r_q) - j))) ||
            (pos_q[j] == (cand >> (int'(r_q) - j)))) begin
          safe = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < N; i++) pos_d[i] = pos_q[i];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          r_d      = '0;
          pos_d[0] = COL0;
          cnt_d    = '0;
          state_d  = S_SEARCH;
        end
      end

      S_SEARCH: begin
        if (cand == '0) begin
          if (r_q == '0) begin
            state_d = S_DONE;
          end else begin
            // Row exhausted: backtrack and advance the parent row.
            r_d                = r_q - 1'b1;
            pos_d[r_q - 1'b1]  = pos_q[r_q - 1'b1] >> 1;
          end
        end else if (!safe) begin
          pos_d[r_q] = cand >> 1;
        end else if (r_q != LAST_ROW) begin
          r_d               = r_q + 1'b1;
          pos_d[r_q + 1'b1] = COL0;
        end else begin
          k_d     = '0;
          state_d = S_EMIT;
        end
      end

      S_EMIT: begin
        if (out_ready) begin
          if (k_q == LAST_ROW) begin
            k_d          = '0;
            cnt_d        = cnt_q + 1'b1;
            // Move the last row on so the search resumes past this solution.
            pos_d[N-1]   = pos_q[N-1] >> 1;
`ifdef NQUEEN_FIRST_ONLY_EN
            state_d      = S_DONE;
`else
            state_d      = S_SEARCH;
`endif
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < N; i++) pos_q[i] <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < N; i++) pos_q[i] <= pos_d[i];
    end
  end

  // Outputs decode registered state only; data and row read zero outside EMIT.
  always_comb begin
    busy           = (state_q == S_SEARCH) || (state_q == S_EMIT);
    done           = (state_q == S_DONE);
    out_valid      = (state_q == S_EMIT);
    out_data       = out_valid ? pos_q[k_q] : '0;
    out_row        = out_valid ? k_q : '0;
    out_last       = out_valid && (k_q == LAST_ROW);
    solution_count = cnt_q;
  end

endmodule
